switch_debounce3: RTL and testbench

//  Conditions three raw lab switch/button inputs into clean, glitch-free levels X, Y, Z.

---
 rtl/lab_pkg.sv | 17 +
 rtl/circuit4.sv | 11 +
 rtl/debounce_ch.sv | 78 +++++++
 rtl/switch_debounce3.sv | 37 +++
 tb/tb_switch_debounce3.sv | 130 +++++++++++++
 5 files changed

// File: rtl/lab_pkg.sv
// Shared constants for the three-switch lab front end: FSM state encoding,
// channel count and the bit position of each switch on the bus.
package lab_pkg;

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    localparam int NUM_CH = 3;
    localparam int IDX_X  = 2;
    localparam int IDX_Y  = 1;
    localparam int IDX_Z  = 0;

endpackage

// File: rtl/circuit4.sv
// Combinational function stage fed by the debounced levels: A = X + Y + Z.
module circuit4 (
    input  logic i_x,
    input  logic i_y,
    input  logic i_z,
    output logic o_a
);

    assign o_a = i_x | i_y | i_z;

endmodule

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability-count FSM and registered
// level / rise / fall outputs.
module debounce_ch
    import lab_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_e                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic                   r_db, r_rise, r_fall;
    logic                   w_s, w_db_nxt, w_rise_nxt, w_fall_nxt;

    assign w_s  = r_sync[SYNC_STAGES-1];
    assign db   = r_db;
    assign rise = r_rise;
    assign fall = r_fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_state <= ST_LO;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], sw};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_db    <= w_db_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Any sample disagreeing with the pending level drops back to the stable state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LO:   if (w_s) w_state_nxt = WAIT_HI;
            WAIT_HI: if (!w_s) w_state_nxt = ST_LO;
                     else if (r_cnt == CNT_LAST) w_state_nxt = ST_HI;
            ST_HI:   if (!w_s) w_state_nxt = WAIT_LO;
            WAIT_LO: if (w_s) w_state_nxt = ST_HI;
                     else if (r_cnt == CNT_LAST) w_state_nxt = ST_LO;
            default: w_state_nxt = ST_LO;
        endcase
    end

    always_comb begin
        w_cnt_nxt = '0;
        case (r_state)
            ST_LO:   if (w_s) w_cnt_nxt = CNT_ONE;
            WAIT_HI: if (w_s && r_cnt != CNT_LAST) w_cnt_nxt = r_cnt + CNT_ONE;
            ST_HI:   if (!w_s) w_cnt_nxt = CNT_ONE;
            WAIT_LO: if (!w_s && r_cnt != CNT_LAST) w_cnt_nxt = r_cnt + CNT_ONE;
            default: w_cnt_nxt = '0;
        endcase
        w_db_nxt   = (w_state_nxt == ST_HI) || (w_state_nxt == WAIT_LO);
        w_rise_nxt = (r_state == WAIT_HI) && (w_state_nxt == ST_HI);
        w_fall_nxt = (r_state == WAIT_LO) && (w_state_nxt == ST_LO);
    end

endmodule

// File: rtl/switch_debounce3.sv
// Three independent debounce channels for the {x,y,z} lab switches plus a
// combined change flag for downstream counters and LEDs.
module switch_debounce3
    import lab_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] sw_in,
    output logic [NUM_CH-1:0] db_out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              chg_any
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .sw   (sw_in[i]),
            .db   (db_out[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    // Pulses are already registered, so the OR lands in the same cycle.
    assign chg_any = |(rise | fall);

endmodule

// File: tb/tb_switch_debounce3.sv
// Directed bench for switch_debounce3 with SYNC_STAGES=2, STABLE_CYCLES=4,
// plus an end-to-end run through the function stage.
module tb_switch_debounce3;
    import lab_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw_in = 3'b000;
    logic [2:0] db_out, rise, fall;
    logic       chg_any, a_out;
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [2:0] hist [0:6];
    int         hold;

    always #5 clk = ~clk;

    switch_debounce3 #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_in  (sw_in),
        .db_out (db_out),
        .rise   (rise),
        .fall   (fall),
        .chg_any(chg_any)
    );

    circuit4 u_fn (
        .i_x(db_out[IDX_X]),
        .i_y(db_out[IDX_Y]),
        .i_z(db_out[IDX_Z]),
        .o_a(a_out)
    );

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    endtask

    // Expected chg_any is derived from the expected pulses.
    task automatic chk_all(input string tag, input logic [2:0] e_db, input logic [2:0] e_r,
                           input logic [2:0] e_f);
        chk(tag, {db_out, rise, fall, chg_any}, {e_db, e_r, e_f, |(e_r | e_f)});
    endtask

    // Apply new_sw just before edge 1; the change must land at edge 6 only.
    task automatic run_edge(input string tag, input logic [2:0] new_sw, input logic [2:0] old_db,
                            input logic [2:0] new_db, input logic [2:0] e_r, input logic [2:0] e_f);
        sw_in = new_sw;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j < 6)       chk_all(tag, old_db, 3'b000, 3'b000);
            else if (j == 6) chk_all(tag, new_db, e_r, e_f);
            else             chk_all(tag, new_db, 3'b000, 3'b000);
        end
    endtask

    initial begin
        // 1. reset then idle
        rst_n = 1'b0;
        sw_in = 3'b000;
        repeat (2) @(negedge clk);
        chk_all("reset", 3'b000, 3'b000, 3'b000);
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk_all("idle", 3'b000, 3'b000, 3'b000);
        end

        // 2. clean edge on x and back
        run_edge("clean_rise", 3'b100, 3'b000, 3'b100, 3'b100, 3'b000);
        run_edge("clean_fall", 3'b000, 3'b100, 3'b000, 3'b000, 3'b100);

        // 3. glitch of 3 cycles rejected, 4 cycles accepted
        sw_in = 3'b010;
        repeat (3) @(negedge clk);
        sw_in = 3'b000;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk_all("glitch_rej", 3'b000, 3'b000, 3'b000);
        end
        sw_in = 3'b010;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            chk_all("glitch_acc", (j >= 6 && j < 10) ? 3'b010 : 3'b000,
                    (j == 6) ? 3'b010 : 3'b000, (j == 10) ? 3'b010 : 3'b000);
            if (j == 4) sw_in = 3'b000;
        end

        // 4. simultaneous changes
        run_edge("simul_rise", 3'b111, 3'b000, 3'b111, 3'b111, 3'b000);
        run_edge("simul_fall", 3'b010, 3'b111, 3'b010, 3'b000, 3'b101);
        run_edge("simul_clr",  3'b000, 3'b010, 3'b000, 3'b000, 3'b010);

        // 5. reset mid-count, input held high across release
        sw_in = 3'b001;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_all("rst_mid", 3'b000, 3'b000, 3'b000);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk_all("rst_release", (j >= 6) ? 3'b001 : 3'b000,
                    (j == 6) ? 3'b001 : 3'b000, 3'b000);
        end
        run_edge("rst_fall", 3'b000, 3'b001, 3'b000, 3'b000, 3'b001);

        // 6. end-to-end random toggles at >= 10-cycle spacing
        for (int k = 0; k < 7; k++) hist[k] = 3'b000;
        hold = 0;
        for (int t = 0; t < 400; t++) begin
            if (hold == 0) begin
                sw_in = sw_in ^ 3'($urandom_range(1, 7));
                hold  = 10 + int'($urandom_range(0, 5));
            end
            hold--;
            @(negedge clk);
            for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = sw_in;
            chk_all("e2e", hist[5], hist[5] & ~hist[6], ~hist[5] & hist[6]);
            chk("e2e_fnA", {9'd0, a_out}, {9'd0, |hist[5]});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
